// File: rtl/itr_arbiter.sv
// Interrupt arbiter: edge-latched pending sources, maskable, lowest-index-first dispatch
// with an end-of-interrupt handshake. Optional service timeout via ITR_ARBITER_TIMEOUT_EN.
module itr_arbiter #(
    parameter int unsigned NSRC       = 4,
    parameter int unsigned NUBITS     = 16,
    parameter int unsigned NUIOIN     = 2,
    parameter int unsigned NUIOOU     = 2,
    parameter int unsigned CAUSE_ADDR = 0,
    parameter int unsigned MASK_ADDR  = 0,
    parameter int unsigned EOI_ADDR   = 1,
    parameter int unsigned TMOUT      = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NSRC-1:0]            irq_src,
    input  logic                       req_in,
    input  logic [$clog2(NUIOIN)-1:0]  addr_in,
    input  logic                       out_en,
    input  logic [$clog2(NUIOOU)-1:0]  addr_out,
    input  logic [NUBITS-1:0]          io_out,
    output logic                       itr,
    output logic [NUBITS-1:0]          rd_data,
    output logic                       rd_hit
);

    localparam int unsigned IDW = $clog2(NSRC);
    localparam int unsigned AIW = $clog2(NUIOIN);
    localparam int unsigned AOW = $clog2(NUIOOU);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_SERVICE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [NSRC-1:0]   irq_prev_q;
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [NSRC-1:0]   mask_q, mask_d;
    logic [IDW-1:0]    cause_id_q, cause_id_d;
    logic              itr_q, itr_d;
    logic              tmo_flag_q, tmo_flag_d;

    logic [NSRC-1:0]   irq_rise;
    logic [NSRC-1:0]   elig;
    logic [NSRC-1:0]   dispatch_clr;
    logic [IDW-1:0]    sel_id;
    logic              eoi_wr;
    logic              mask_wr;
    logic              tmo_hit;
    logic              tmo_set;
    logic [NUBITS-1:0] cause_word;

    // Processor-side decode
    assign irq_rise = irq_src & ~irq_prev_q;
    assign eoi_wr   = out_en && (addr_out == AOW'(EOI_ADDR));
    assign mask_wr  = out_en && (addr_out == AOW'(MASK_ADDR));
    assign elig     = pending_q & mask_q;
    assign rd_hit   = req_in && (addr_in == AIW'(CAUSE_ADDR));

    // Lowest index wins: scan downward so the last match is the smallest id
    always_comb begin
        sel_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel_id = IDW'(i);
            end
        end
    end

`ifdef ITR_ARBITER_TIMEOUT_EN
    localparam int unsigned CW = (TMOUT > 1) ? $clog2(TMOUT) : 1;

    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero while idle so every service episode starts counting from zero
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == S_IDLE) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
    end

    assign tmo_hit = (state_q == S_SERVICE) && (tmo_cnt_q == CW'(TMOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Dispatch / service FSM
    always_comb begin
        state_d      = state_q;
        cause_id_d   = cause_id_q;
        itr_d        = 1'b0;
        dispatch_clr = '0;
        tmo_set      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    cause_id_d   = sel_id;
                    dispatch_clr = NSRC'(1) << sel_id;
                    itr_d        = 1'b1;
                    state_d      = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (eoi_wr) begin
                    state_d = S_IDLE;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    tmo_set = 1'b1;
                end
            end
        endcase
    end

    // A new edge on the bit being dispatched survives the clear
    always_comb begin
        pending_d  = (pending_q & ~dispatch_clr) | irq_rise;
        mask_d     = mask_wr ? io_out[NSRC-1:0] : mask_q;
        tmo_flag_d = tmo_flag_q;
        if (tmo_set) begin
            tmo_flag_d = 1'b1;
        end else if (rd_hit) begin
            tmo_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            cause_id_q <= '0;
            itr_q      <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_src;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            cause_id_q <= cause_id_d;
            itr_q      <= itr_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    // Cause word: id in low bits, in-service and timeout flags at the top
    always_comb begin
        cause_word             = '0;
        cause_word[IDW-1:0]    = cause_id_q;
        cause_word[NUBITS-2]   = (state_q == S_SERVICE);
        cause_word[NUBITS-1]   = tmo_flag_q;
    end

    assign rd_data = rd_hit ? cause_word : '0;
    assign itr     = itr_q;

    logic unused_ok;
    assign unused_ok = ^{io_out, 32'(TMOUT)};

endmodule

// File: tb/tb_itr_arbiter.sv
// Self-checking bench for itr_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the arbitration rules.
module tb_itr_arbiter;

    localparam int unsigned NSRC   = 4;
    localparam int unsigned NUBITS = 16;
    localparam int          TMO    = 8;
`ifdef ITR_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NSRC-1:0]   irq_src;
    logic              req_in;
    logic              addr_in;
    logic              out_en;
    logic              addr_out;
    logic [NUBITS-1:0] io_out;
    logic              itr;
    logic [NUBITS-1:0] rd_data;
    logic              rd_hit;

    itr_arbiter #(
        .NSRC  (NSRC),
        .NUBITS(NUBITS),
        .TMOUT (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .req_in  (req_in),
        .addr_in (addr_in),
        .out_en  (out_en),
        .addr_out(addr_out),
        .io_out  (io_out),
        .itr     (itr),
        .rd_data (rd_data),
        .rd_hit  (rd_hit)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sets of pending/enabled sources, a busy flag and the
    // cycle on which the current service began.
    bit [NSRC-1:0] m_prev, m_pend, m_mask;
    bit            m_busy, m_flag, m_itr;
    int            m_id, m_start, cyc;

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_mask = '0;
        m_busy = 0; m_flag = 0; m_itr = 0;
        m_id = 0; m_start = 0;
    endtask

    function automatic logic [15:0] exp_cause();
        logic [15:0] w;
        w       = '0;
        w[1:0]  = 2'(m_id);
        w[14]   = m_busy;
        w[15]   = m_flag;
        return w;
    endfunction

    task automatic model_step();
        bit [NSRC-1:0] rise, clr, elig;
        bit eoi, mw, rd, set_flag;
        int k;
        cyc++;
        rise = irq_src & ~m_prev;
        clr = '0;
        eoi = out_en && (addr_out == 1'b1);
        mw  = out_en && (addr_out == 1'b0);
        rd  = req_in && (addr_in == 1'b0);
        set_flag = 0;
        m_itr = 0;
        if (!m_busy) begin
            elig = m_pend & m_mask;
            if (elig != 0) begin
                k = 0;
                for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) k = i;
                m_id = k; clr[k] = 1'b1; m_itr = 1; m_busy = 1; m_start = cyc;
            end
        end else if (eoi) begin
            m_busy = 0;
        end else if (TO_EN && (cyc - m_start == TMO)) begin
            m_busy = 0; set_flag = 1;
        end
        if (set_flag) m_flag = 1;
        else if (rd) m_flag = 0;
        m_pend = (m_pend & ~clr) | rise;
        if (mw) m_mask = io_out[NSRC-1:0];
        m_prev = irq_src;
    endtask

    // One clock: check combinational read path, advance, check itr
    task automatic tick();
        logic hit;
        #1;
        hit = req_in && (addr_in == 1'b0);
        check_val("rd_hit", rd_hit, hit);
        check_val("rd_data", rd_data, hit ? exp_cause() : 16'h0);
        @(posedge clk);
        model_step();
        #1;
        check_val("itr", itr, m_itr);
    endtask

    task automatic do_write(input logic a, input logic [15:0] d);
        out_en = 1'b1; addr_out = a; io_out = d;
        tick();
        out_en = 1'b0; io_out = '0;
    endtask

    task automatic expect_read(input string tag, input logic [15:0] exp);
        req_in = 1'b1; addr_in = 1'b0;
        #1;
        check_val(tag, rd_data, exp);
        tick();
        req_in = 1'b0;
    endtask

    task automatic expect_itr(input string tag, input logic exp);
        tick();
        check_val(tag, itr, exp);
    endtask

    initial begin
        rst = 1'b0; irq_src = '0; req_in = 1'b0; addr_in = 1'b0;
        out_en = 1'b0; addr_out = 1'b0; io_out = '0; cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_itr", itr, 1'b0);
        req_in = 1'b1;
        #1;
        check_val("reset_hit", rd_hit, 1'b1);
        check_val("reset_cause", rd_data, 16'h0000);
        req_in = 1'b0;
        rst = 1'b1;
        model_reset();

        // Single source dispatch
        do_write(1'b0, 16'h000F);
        irq_src[2] = 1'b1;
        expect_itr("r028_edge", 1'b0);
        expect_itr("r028_pulse", 1'b1);
        expect_read("r028_cause", 16'h4002);
        check_val("r028_fall", itr, 1'b0);
        do_write(1'b1, 16'h0000);
        for (int i = 0; i < 3; i++) expect_itr("r028_noretrig", 1'b0);
        irq_src = '0;
        tick();

        // Simultaneous edges, lowest first
        irq_src = 4'b1010;
        expect_itr("r029_edge", 1'b0);
        expect_itr("r029_first", 1'b1);
        expect_read("r029_cause1", 16'h4001);
        tick();
        do_write(1'b1, 16'h0000);
        expect_itr("r029_second", 1'b1);
        expect_read("r029_cause3", 16'h4003);
        do_write(1'b1, 16'h0000);
        irq_src = '0;
        tick(); tick();

        // Masked source held until enabled
        do_write(1'b0, 16'h0000);
        irq_src[0] = 1'b1;
        for (int i = 0; i < 4; i++) expect_itr("r030_masked", 1'b0);
        do_write(1'b0, 16'h0001);
        check_val("r030_at_write", itr, 1'b0);
        expect_itr("r030_pulse", 1'b1);
        expect_read("r030_cause", 16'h4000);

        // New edge during service waits for EOI
        irq_src[0] = 1'b0;
        tick();
        irq_src[0] = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) expect_itr("r031_hold", 1'b0);
        do_write(1'b1, 16'h0000);
        check_val("r031_at_eoi", itr, 1'b0);
        expect_itr("r031_after_eoi", 1'b1);
        expect_read("r031_cause", 16'h4000);

        // Service without EOI
        irq_src = '0;
        for (int i = 0; i < 12; i++) tick();
        if (TO_EN) begin
            expect_read("r032_flag", 16'h8000);
            expect_read("r032_cleared", 16'h0000);
        end else begin
            expect_read("r032_busy", 16'h4000);
            expect_read("r032_still_busy", 16'h4000);
        end
        do_write(1'b1, 16'h0000);
        expect_read("r032_idle", 16'h0000);

        // Reset during service with another source pending
        do_write(1'b0, 16'h000F);
        irq_src[1] = 1'b1;
        tick();
        expect_itr("r033_pulse", 1'b1);
        irq_src[1] = 1'b0;
        tick();
        irq_src[1] = 1'b1;
        tick();
        #2;
        rst = 1'b0; irq_src = '0;
        model_reset();
        #1;
        check_val("r033_rst_itr", itr, 1'b0);
        req_in = 1'b1;
        #1;
        check_val("r033_rst_cause", rd_data, 16'h0000);
        req_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        do_write(1'b0, 16'h000F);
        for (int i = 0; i < 5; i++) expect_itr("r033_quiet", 1'b0);
        irq_src[1] = 1'b1;
        expect_itr("r033_edge", 1'b0);
        expect_itr("r033_new", 1'b1);
        expect_read("r033_cause", 16'h4001);
        do_write(1'b1, 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [NSRC-1:0] f;
            for (int b = 0; b < NSRC; b++) f[b] = ($urandom_range(3) == 0);
            irq_src  = irq_src ^ f;
            req_in   = 1'($urandom_range(1));
            addr_in  = 1'($urandom_range(1));
            out_en   = ($urandom_range(5) == 0);
            addr_out = 1'($urandom_range(1));
            io_out   = 16'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/itr_arbiter.md
ITR_ARBITER -- requirements
Module: itr_arbiter

Interface
REQ-001 SHALL have parameter NSRC, default 4, number of interrupt sources (2..16).
REQ-002 SHALL have parameter NUBITS, default 16, processor word width.
REQ-003 SHALL have parameter NUIOIN, default 2, processor input address count.
REQ-004 SHALL have parameter NUIOOU, default 2, processor output address count.
REQ-005 SHALL have parameters CAUSE_ADDR (default 0, input addr), MASK_ADDR (default 0, output addr), EOI_ADDR (default 1, output addr), TMOUT (default 1024, service timeout cycles).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-008 SHALL have port irq_src  input  NSRC  interrupt sources, synchronous to clk.
REQ-009 SHALL have ports req_in input 1, addr_in input $clog2(NUIOIN): processor read strobe/address.
REQ-010 SHALL have ports out_en input 1, addr_out input $clog2(NUIOOU), io_out input NUBITS: processor write strobe/address/data.
REQ-011 SHALL have port itr  output  1  interrupt request to processor core.
REQ-012 SHALL have ports rd_data output NUBITS, rd_hit output 1: cause word and its select for the system io_in mux.

Function
REQ-013 SHALL latch pending[i] on a rising edge of irq_src[i] (registered previous value 0, current 1); level alone SHALL NOT re-trigger.
REQ-014 SHALL hold mask register (NSRC bits, 1 = enabled), written from io_out[NSRC-1:0] when out_en and addr_out==MASK_ADDR.
REQ-015 SHALL implement FSM IDLE -> SERVICE; IDLE with (pending & mask)!=0 selects lowest-index enabled pending source, stores its id in cause, clears that pending bit, pulses itr high one cycle, enters SERVICE.
REQ-016 Latency: edge sampled at clock k sets pending at k; itr SHALL be high during the cycle following clock k+1.
REQ-017 SERVICE SHALL dispatch nothing; pending bits keep latching; out_en with addr_out==EOI_ADDR returns to IDLE (data ignored).
REQ-018 Pending set and dispatch-clear of same bit on same edge: set SHALL win (bit stays pending).
REQ-019 Masked pending bits SHALL be retained and dispatched once unmasked.
REQ-020 EOI in IDLE SHALL be ignored; EOI and new pending on same edge: return to IDLE, dispatch next cycle.
REQ-021 rd_hit = req_in && addr_in==CAUSE_ADDR (combinational); rd_data = cause word when rd_hit, else 0.
REQ-022 Cause word: bits[$clog2(NSRC)-1:0] source id, bit NUBITS-2 in-service (state==SERVICE), bit NUBITS-1 timeout flag, others 0.
REQ-023 Reading the cause word SHALL clear the timeout flag at the end of the read cycle.

Reset
REQ-024 On rst low, asynchronously: itr=0, pending=0, mask=0, cause id=0, timeout flag=0, state IDLE, edge registers=0; rd_data/rd_hit follow REQ-021.
REQ-025 Reset mid-SERVICE SHALL abandon service; no itr until a new edge after rst release.

Configuration
REQ-026 Macro ITR_ARBITER_TIMEOUT_EN defined: SERVICE counter counts clocks; reaching TMOUT without EOI forces IDLE and sets timeout flag; counter clears on SERVICE entry.
REQ-027 Macro undefined: no counter, timeout flag reads 0, SERVICE exits only by EOI or reset.

Verification
REQ-028 Mask=4'b1111, irq_src[2] 0->1 -> itr pulse 2 clocks later, cause read = 0x4002, pending[2] cleared.
REQ-029 irq_src[1] and [3] rise same cycle, mask=4'b1111 -> itr with id 1; after EOI, second itr with id 3.
REQ-030 Mask=0, irq_src[0] rises, then mask write 4'b0001 -> no itr before write, itr one clock after write.
REQ-031 In SERVICE, irq_src[0] rises -> no itr until EOI; itr follows EOI, cause id 0.
REQ-032 With ITR_ARBITER_TIMEOUT_EN, TMOUT=8, no EOI -> IDLE after 8 clocks, cause read = 0x8000|id, flag clears after read.
REQ-033 rst low during SERVICE with pending[1] set -> itr=0, pending=0, no itr after release until new edge.
